// File: rtl/parking_request_scheduler_if.sv
// Request/job bus between the parking-lot front end, the scheduler and the elevator controller.
// master = front end + elevator side (drives requests and job handshake), slave = scheduler.
interface parking_request_scheduler_if #(
  parameter int CNT_W = 4
);
  logic [15:0]      license_plate;
  logic             in_mode;
  logic             out_mode;
  logic             leakage;
  logic [2:0]       leakage_floor;
  logic             job_ready;
  logic             job_done;
  logic             todo_valid;
  logic             todo_exists;
  logic             todo_in;
  logic             todo_out;
  logic             todo_leak_move;
  logic [15:0]      todo_license_plate;
  logic [2:0]       todo_floor;
  logic [CNT_W-1:0] queue_count;
  logic             overflow;

  modport master (
    output license_plate, in_mode, out_mode, leakage, leakage_floor, job_ready, job_done,
    input  todo_valid, todo_exists, todo_in, todo_out, todo_leak_move,
           todo_license_plate, todo_floor, queue_count, overflow
  );

  modport slave (
    input  license_plate, in_mode, out_mode, leakage, leakage_floor, job_ready, job_done,
    output todo_valid, todo_exists, todo_in, todo_out, todo_leak_move,
           todo_license_plate, todo_floor, queue_count, overflow
  );
endinterface

// File: rtl/parking_request_scheduler.sv
// Queues park-in/out requests, holds a priority leak job, issues one job at a time (valid/ready + done).
// Job offered one edge after a request lands; full FIFO drops pushes (sticky overflow). REQ_DEDUP_EN drops duplicates.
module parking_request_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  parking_request_scheduler_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t state, state_n;

  logic             mem_out   [DEPTH];
  logic [15:0]      mem_plate [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;

  logic        leak_pending, leak_pending_n;
  logic [2:0]  leak_floor;

  logic        cur_in, cur_out, cur_leak;
  logic [15:0] cur_plate;
  logic [2:0]  cur_floor;

  logic exists_q, overflow_q;

  logic push_req, req_type, dup, push_ok, drop;
  logic fifo_empty, fifo_full;
  logic accept, pop, leak_take, leak_set;
  logic load, clear;

  assign req_type   = bus.out_mode;
  assign push_req   = (bus.in_mode ^ bus.out_mode) && (bus.license_plate != 16'h0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));

  assign accept    = (state == OFFER) && bus.job_ready;
  assign pop       = accept && !cur_leak;
  assign leak_take = accept && cur_leak;
  assign leak_set  = bus.leakage && (bus.leakage_floor != 3'd0);

`ifdef REQ_DEDUP_EN
  logic ent_vld [DEPTH];

  always_comb begin
    dup = 1'b0;
    if ((state != IDLE) && !cur_leak && (cur_out == req_type) && (cur_plate == bus.license_plate))
      dup = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (mem_out[i] == req_type) && (mem_plate[i] == bus.license_plate))
        dup = 1'b1;
    end
  end

  // clear before set so a full-FIFO push+pop onto the same slot keeps it valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_vld[i] <= 1'b0;
    end else begin
      if (pop)     ent_vld[rd_ptr] <= 1'b0;
      if (push_ok) ent_vld[wr_ptr] <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push_ok = push_req && !dup && (!fifo_full || pop);
  assign drop    = push_req && !dup && fifo_full && !pop;

  assign count_n        = count + CNT_W'(push_ok) - CNT_W'(pop);
  assign leak_pending_n = leak_set | (leak_pending & ~leak_take);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_out[i]   <= 1'b0;
        mem_plate[i] <= 16'h0;
      end
    end else begin
      if (push_ok) begin
        mem_out[wr_ptr]   <= req_type;
        mem_plate[wr_ptr] <= bus.license_plate;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leak_pending <= 1'b0;
      leak_floor   <= 3'd0;
      overflow_q   <= 1'b0;
    end else begin
      leak_pending <= leak_pending_n;
      if (leak_set) leak_floor <= bus.leakage_floor;
      if (drop)     overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      IDLE: begin
        if (leak_pending || !fifo_empty) begin
          state_n = OFFER;
          load    = 1'b1;
        end
      end
      OFFER: begin
        if (bus.job_ready) state_n = BUSY;
      end
      BUSY: begin
        if (bus.job_done) begin
          state_n = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // leak wins selection; fields then stay frozen until the job completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_in    <= 1'b0;
      cur_out   <= 1'b0;
      cur_leak  <= 1'b0;
      cur_plate <= 16'h0;
      cur_floor <= 3'd0;
    end else if (load) begin
      if (leak_pending) begin
        cur_in    <= 1'b0;
        cur_out   <= 1'b0;
        cur_leak  <= 1'b1;
        cur_plate <= 16'h0;
        cur_floor <= leak_floor;
      end else begin
        cur_in    <= !mem_out[rd_ptr];
        cur_out   <= mem_out[rd_ptr];
        cur_leak  <= 1'b0;
        cur_plate <= mem_plate[rd_ptr];
        cur_floor <= 3'd0;
      end
    end else if (clear) begin
      cur_in    <= 1'b0;
      cur_out   <= 1'b0;
      cur_leak  <= 1'b0;
      cur_plate <= 16'h0;
      cur_floor <= 3'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) exists_q <= 1'b0;
    else        exists_q <= (state_n != IDLE) | leak_pending_n | (count_n != '0);
  end

  assign bus.todo_valid         = (state == OFFER);
  assign bus.todo_exists        = exists_q;
  assign bus.todo_in            = cur_in;
  assign bus.todo_out           = cur_out;
  assign bus.todo_leak_move     = cur_leak;
  assign bus.todo_license_plate = cur_plate;
  assign bus.todo_floor         = cur_floor;
  assign bus.queue_count        = count;
  assign bus.overflow           = overflow_q;

endmodule

// File: tb/tb_parking_request_scheduler.sv
// Directed bench for parking_request_scheduler; expectations are hand-derived from the job flow.
module tb_parking_request_scheduler;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [15:0] seen_plate;

  parking_request_scheduler_if #(.CNT_W(4)) bus ();

  parking_request_scheduler #(.DEPTH(8), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic in_m, input logic out_m, input logic [15:0] plate);
    bus.in_mode       = in_m;
    bus.out_mode      = out_m;
    bus.license_plate = plate;
    tick();
    bus.in_mode       = 1'b0;
    bus.out_mode      = 1'b0;
    bus.license_plate = 16'h0;
  endtask

  task automatic accept_job();
    bus.job_ready = 1'b1;
    tick();
    bus.job_ready = 1'b0;
  endtask

  task automatic finish_job();
    bus.job_done = 1'b1;
    tick();
    bus.job_done = 1'b0;
  endtask

  task automatic leak(input logic [2:0] floor);
    bus.leakage       = 1'b1;
    bus.leakage_floor = floor;
    tick();
    bus.leakage       = 1'b0;
    bus.leakage_floor = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.license_plate = 16'h0;
    bus.in_mode       = 1'b0;
    bus.out_mode      = 1'b0;
    bus.leakage       = 1'b0;
    bus.leakage_floor = 3'd0;
    bus.job_ready     = 1'b0;
    bus.job_done      = 1'b0;
    do_reset();

    chk("rst_valid",    bus.todo_valid, 0);
    chk("rst_exists",   bus.todo_exists, 0);
    chk("rst_count",    bus.queue_count, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_plate",    bus.todo_license_plate, 0);

    // basic park-in with job_ready held high
    bus.job_ready = 1'b1;
    push(1'b1, 1'b0, 16'h9423);
    chk("t1_count1", bus.queue_count, 1);
    chk("t1_novalid", bus.todo_valid, 0);
    tick();
    chk("t1_valid", bus.todo_valid, 1);
    chk("t1_in", bus.todo_in, 1);
    chk("t1_plate", bus.todo_license_plate, 16'h9423);
    tick();
    bus.job_ready = 1'b0;
    chk("t1_count0", bus.queue_count, 0);
    chk("t1_busy_valid", bus.todo_valid, 0);
    chk("t1_busy_exists", bus.todo_exists, 1);
    finish_job();
    chk("t1_done_in", bus.todo_in, 0);
    chk("t1_done_exists", bus.todo_exists, 0);

    // out request held while the in job is busy
    push(1'b1, 1'b0, 16'h8754);
    tick();
    accept_job();
    push(1'b0, 1'b1, 16'h8754);
    chk("t2_held", bus.queue_count, 1);
    chk("t2_busy_plate", bus.todo_license_plate, 16'h8754);
    chk("t2_busy_in", bus.todo_in, 1);
    finish_job();
    tick();
    chk("t2_valid", bus.todo_valid, 1);
    chk("t2_out", bus.todo_out, 1);
    chk("t2_plate", bus.todo_license_plate, 16'h8754);
    accept_job();
    finish_job();

    // leak overtakes queued requests
    push(1'b1, 1'b0, 16'h1111);
    tick();
    accept_job();
    push(1'b1, 1'b0, 16'h5755);
    push(1'b1, 1'b0, 16'h3851);
    chk("t3_count2", bus.queue_count, 2);
    leak(3'd3);
    finish_job();
    tick();
    chk("t3_leak_valid", bus.todo_valid, 1);
    chk("t3_leak_move", bus.todo_leak_move, 1);
    chk("t3_leak_floor", bus.todo_floor, 3);
    chk("t3_leak_plate", bus.todo_license_plate, 0);
    chk("t3_leak_count", bus.queue_count, 2);
    accept_job();
    chk("t3_leak_nopop", bus.queue_count, 2);
    finish_job();
    tick();
    chk("t3_next_in", bus.todo_in, 1);
    chk("t3_next_plate", bus.todo_license_plate, 16'h5755);
    chk("t3_next_floor", bus.todo_floor, 0);
    accept_job();
    finish_job();
    tick();
    chk("t3_last_plate", bus.todo_license_plate, 16'h3851);
    accept_job();
    finish_job();
    chk("t3_empty_exists", bus.todo_exists, 0);

    // fill, overflow, then push+pop at full
    for (int i = 0; i < 8; i++) push(1'b1, 1'b0, 16'h1001 + 16'(i));
    chk("t4_full", bus.queue_count, 8);
    chk("t4_no_ovf", bus.overflow, 0);
    push(1'b1, 1'b0, 16'h1009);
    chk("t4_ovf_count", bus.queue_count, 8);
    chk("t4_ovf", bus.overflow, 1);
    chk("t4_head", bus.todo_license_plate, 16'h1001);
    bus.job_ready = 1'b1;
    push(1'b1, 1'b0, 16'h2000);
    bus.job_ready = 1'b0;
    chk("t4_pp_count", bus.queue_count, 8);
    chk("t4_pp_ovf", bus.overflow, 1);
    chk("t4_pp_busy", bus.todo_valid, 0);
    finish_job();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_drain_valid", bus.todo_valid, 1);
      seen_plate = bus.todo_license_plate;
      if (i == 0) chk("t4_drain_first", seen_plate, 16'h1002);
      accept_job();
      finish_job();
    end
    chk("t4_drain_last", seen_plate, 16'h2000);
    chk("t4_drained", bus.queue_count, 0);
    chk("t4_ovf_sticky", bus.overflow, 1);
    do_reset();
    chk("t4_ovf_cleared", bus.overflow, 0);

    // ignored requests
    push(1'b1, 1'b1, 16'h1234);
    push(1'b1, 1'b0, 16'h0000);
    leak(3'd0);
    tick();
    chk("t5_count", bus.queue_count, 0);
    chk("t5_exists", bus.todo_exists, 0);
    chk("t5_valid", bus.todo_valid, 0);

    // duplicate request, then reset during busy
    push(1'b1, 1'b0, 16'h9522);
    push(1'b1, 1'b0, 16'h9522);
`ifdef REQ_DEDUP_EN
    chk("t6_dup_count", bus.queue_count, 1);
`else
    chk("t6_dup_count", bus.queue_count, 2);
`endif
    chk("t6_offer_plate", bus.todo_license_plate, 16'h9522);
    accept_job();
    chk("t6_busy_in", bus.todo_in, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_in", bus.todo_in, 0);
    chk("t6_rst_plate", bus.todo_license_plate, 0);
    chk("t6_rst_exists", bus.todo_exists, 0);
    chk("t6_rst_count", bus.queue_count, 0);
    chk("t6_rst_valid", bus.todo_valid, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t6_no_residual", bus.todo_exists, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_request_scheduler.md
Name: parking_request_scheduler

Overview:
- Sits between the parking-lot front-end inputs (in_mode/out_mode/leakage) and the elevator/placement controller inside the parking-lot top.
- Captures one-cycle request pulses and buffers park-in/park-out requests in a FIFO.
- Holds leakage evacuation as a separate priority request, and issues one job at a time to the elevator controller with a valid/ready + done handshake.
- Drives the todo_* status signals shown on the top-level debug display.

Parameters:
- DEPTH, 8, normal-request FIFO entries (power of 2, ≥2)
- CNT_W, 4, width of queue_count, equal to log2(DEPTH)+1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- license_plate  in  16  4 BCD digits, sampled together with in_mode/out_mode
- in_mode  in  1  park-in request pulse
- out_mode  in  1  park-out request pulse
- leakage  in  1  leakage event pulse
- leakage_floor  in  3  floor of the leakage event, 1..7
- job_ready  in  1  elevator controller can accept a job
- job_done  in  1  one-cycle pulse when the accepted job completes
- todo_valid  out  1  job offered this cycle
- todo_exists  out  1  any job offered, active or pending
- todo_in  out  1  current job is a park-in
- todo_out  out  1  current job is a park-out
- todo_leak_move  out  1  current job is a leakage evacuation
- todo_license_plate  out  16  plate of the current job (0 for leak)
- todo_floor  out  3  leak floor of the current job (0 for in/out)
- queue_count  out  CNT_W  FIFO occupancy
- overflow  out  1  sticky; set when a request is dropped because the FIFO is full

Behaviour:
- Reset (reset=0, async): FIFO emptied, leak pending cleared, FSM enters IDLE. All outputs are 0.
- Capture at every rising edge:
  - in_mode XOR out_mode, with license_plate≠0 → push {type, plate}.
  - in_mode&out_mode both high, or plate==0 → request ignored, no flag raised.
- Leakage capture: leakage=1 with leakage_floor≠0 → leak_pending=1, leak_floor latched. A newer leakage overwrites the floor (latest wins). leakage_floor=0 is ignored.
- FIFO full with a push and no pop in the same cycle → push dropped, overflow=1 until reset.
- Full FIFO with a push and a pop in the same cycle → both succeed and the count is unchanged.
- FSM states:
  - IDLE → OFFER when leak_pending or FIFO not empty. Selection: leak has priority over the FIFO head. The selected job is latched into the todo_* fields.
  - OFFER: todo_valid=1. Fields are stable until acceptance, with no preemption even if a leak arrives. On todo_valid&job_ready → BUSY, and the FIFO is popped (or leak_pending cleared) in the same edge.
  - BUSY: todo_valid=0, fields held. On job_done → IDLE, todo_in/out/leak_move/plate/floor cleared.
- A leakage arriving while a leak job is in OFFER/BUSY sets leak_pending again and is issued as a new job afterwards.
- job_done in IDLE/OFFER is ignored. job_ready is ignored outside OFFER.
- todo_exists = (state≠IDLE) | leak_pending | (queue_count≠0), registered.
- Latency: a request sampled at edge k → queue_count/leak_pending updated after edge k. State OFFER with todo_valid=1 follows after edge k+1 when idle. Next job reaches OFFER one edge after job_done.
- queue_count counts FIFO entries only (not leak, not the active job). It never exceeds DEPTH and wraps pointers mod DEPTH.
- Reset asserted mid-job aborts immediately. No residual request survives.

Optional Feature:
- Macro: REQ_DEDUP_EN
- Defined: a push whose {type, plate} matches any valid FIFO entry or the latched OFFER/BUSY job is silently discarded. It does not count as overflow. Comparison is combinational across all DEPTH entries.
- Undefined: no comparison logic; duplicate requests are queued normally.

Test Plan:
- Reset, then in_mode pulse with plate 16'h9423, job_ready=1 → queue_count 1 after edge, todo_valid=1 next cycle with todo_in=1 and plate 9423. After acceptance, queue_count 0 and todo_exists=1 until job_done.
- In 8754, then out 8754 while the first job is BUSY → the out job is held in the FIFO. After job_done, the next OFFER has todo_out=1 and plate 8754.
- Queue in 5755 and 3851, then leakage floor 3 during BUSY → after job_done the next OFFER has todo_leak_move=1, todo_floor=3, plate 0. 5755 follows after that job completes.
- Fill DEPTH=8 entries with job_ready=0, then push a 9th → queue_count 8, overflow=1. A simultaneous push and pop at full → count stays 8, overflow unchanged.
- in_mode&out_mode both high; plate 0 with in_mode; leakage_floor 0 → no state change, todo_exists stays 0.
- With REQ_DEDUP_EN, push in 9522 twice → queue_count 1. Without the macro → 2. Reset asserted during BUSY → all outputs 0 immediately.
